// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state, ALU, immediate and opcode encodings for the multicycle controller
package ctrl_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADR    = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXECR     = 4'd6;
  localparam logic [3:0] S_EXECI     = 4'd7;
  localparam logic [3:0] S_ALUWB     = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR      = 4'd11;
  localparam logic [3:0] S_JALR_LINK = 4'd12;
  localparam logic [3:0] S_AUIPC     = 4'd13;
  localparam logic [3:0] S_LUI       = 4'd14;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct7_5 only means SUB for register ops; immediate ops keep bit 30 as part of the immediate
  function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic funct7_5,
                                            input logic is_reg);
    case (funct3)
      3'b000:  alu_decode = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch condition evaluation from funct3 and ALU flags
module branch_unit (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       bad
);

  always_comb begin
    taken = 1'b0;
    bad   = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing a multicycle RV32I datapath
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALUCTL_W      = 4,
  parameter int MEM_HANDSHAKE = 1,
  parameter int INSTRET_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic                 adr_src,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           imm_src,
  output logic [ALUCTL_W-1:0]  alu_control,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state_o
);

  logic [3:0] state, next_state;
  logic [3:0] alu_op;
  logic       run, mem_ok, taken, br_bad, retire;

  assign mem_ok      = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state_o     = state;
  assign alu_control = ALUCTL_W'(alu_op);

  branch_unit u_branch (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .ltu    (ltu),
    .taken  (taken),
    .bad    (br_bad)
  );

  // run holds the FSM idle until the first clock edge after reset releases
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      run     <= 1'b0;
      instret <= '0;
    end else begin
      run   <= 1'b1;
      state <= next_state;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    case (opcode)
      OP_STORE:         imm_src = IMM_S;
      OP_BRANCH:        imm_src = IMM_B;
      OP_JAL:           imm_src = IMM_J;
      OP_AUIPC, OP_LUI: imm_src = IMM_U;
      default:          imm_src = IMM_I;
    endcase
  end

  always_comb begin
    next_state = state;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    adr_src    = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ok) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_AUIPC:          next_state = S_AUIPC;
          OP_LUI:            next_state = S_LUI;
          default: begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ok) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ok) next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = alu_decode(funct3, funct7_5, 1'b1);
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = alu_decode(funct3, funct7_5, 1'b0);
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_SUB;
        pc_write   = taken;
        illegal    = br_bad;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        next_state = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        next_state = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
    if (!run) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      illegal    = 1'b0;
      next_state = S_FETCH;
    end
  end

  assign retire = run && !illegal && (next_state == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                   (state == S_ALUWB) || (state == S_BRANCH));

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for the multicycle controller FSM
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5, zero, lt, ltu, mem_ready;
  logic        ir_write, pc_write, reg_write, mem_write, mem_read, adr_src, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control, state_o;
  logic [31:0] instret;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_instret = 0;

  localparam logic [6:0] D_IR  = 7'b1000000;
  localparam logic [6:0] D_PC  = 7'b0100000;
  localparam logic [6:0] D_ILL = 7'b0000001;

  typedef struct {
    logic        mr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [2:0]  flg;
    logic [23:0] v;
  } item_t;

  item_t sb[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3, cur_flg, cur_imm;
  logic       cur_f7;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
    .mem_read(mem_read), .adr_src(adr_src), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
    .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] obs();
    return {state_o, ir_write, pc_write, reg_write, mem_write, mem_read, adr_src, illegal,
            result_src, alu_src_a, alu_src_b, alu_control, imm_src};
  endfunction

  // strobe order: ir, pc, reg_write, mem_write, mem_read, adr_src, illegal
  function automatic logic [23:0] exp_vec(input logic [3:0] st, input logic [6:0] dyn,
                                          input logic [3:0] alu, input logic [2:0] imm);
    logic [6:0] s;
    logic [1:0] rs, a, b;
    s = '0; rs = 2'd0; a = 2'd0; b = 2'd0;
    case (st)
      4'd0:  begin s = 7'b0000100; rs = 2'd2; b = 2'd2; end
      4'd1:  begin a = 2'd1; b = 2'd1; end
      4'd2:  begin a = 2'd2; b = 2'd1; end
      4'd3:  s = 7'b0000110;
      4'd4:  begin s = 7'b0010000; rs = 2'd1; end
      4'd5:  s = 7'b0001010;
      4'd6:  a = 2'd2;
      4'd7:  begin a = 2'd2; b = 2'd1; end
      4'd8:  s = 7'b0010000;
      4'd9:  a = 2'd2;
      4'd10: begin s = 7'b0100000; a = 2'd1; b = 2'd2; end
      4'd11: begin s = 7'b0100000; a = 2'd2; b = 2'd1; rs = 2'd2; end
      4'd12: begin a = 2'd1; b = 2'd2; end
      4'd13: begin a = 2'd1; b = 2'd1; end
      4'd14: begin a = 2'd3; b = 2'd1; end
      default: ;
    endcase
    return {st, s | dyn, rs, a, b, alu, imm};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [2:0] flg, input logic [2:0] imm);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_flg = flg; cur_imm = imm;
  endtask

  task automatic push(input logic [3:0] st, input logic mr, input logic [6:0] dyn,
                      input logic [3:0] alu);
    item_t it;
    it.mr = mr; it.op = cur_op; it.f3 = cur_f3; it.f7 = cur_f7; it.flg = cur_flg;
    it.v = exp_vec(st, dyn, alu, cur_imm);
    sb.push_back(it);
  endtask

  task automatic push_fd();
    push(4'd0, 1'b1, D_IR | D_PC, ALU_ADD);
    push(4'd1, 1'b1, 7'd0, ALU_ADD);
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1; opcode = OP_R; funct3 = 3'd0; funct7_5 = 1'b0;
    {zero, lt, ltu} = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (state_o !== 4'd0 || instret !== 32'd0) begin
      bad++; $display("FAIL reset_state: state=%0d instret=%0d want 0/0", state_o, instret);
    end
    total++;
    if (obs() >> 13 & 24'h7F) begin
      bad++; $display("FAIL reset_strobes: got %b want 0", obs() >> 13 & 24'h7F);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ((obs() >> 13 & 24'h7F) !== 24'd0) begin
      bad++; $display("FAIL release_idle: strobes %b before first edge want 0", obs() >> 13 & 24'h7F);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_ops();
    item_t it;
    set_instr(OP_R, 3'b000, 1'b0, 3'b000, IMM_I);
    push_fd(); push(4'd6, 1'b1, 7'd0, ALU_ADD); push(4'd8, 1'b1, 7'd0, ALU_ADD);
    set_instr(OP_R, 3'b000, 1'b1, 3'b000, IMM_I);
    push_fd(); push(4'd6, 1'b1, 7'd0, ALU_SUB); push(4'd8, 1'b1, 7'd0, ALU_ADD);
    set_instr(OP_R, 3'b111, 1'b0, 3'b000, IMM_I);
    push_fd(); push(4'd6, 1'b1, 7'd0, ALU_AND); push(4'd8, 1'b1, 7'd0, ALU_ADD);
    set_instr(OP_I, 3'b101, 1'b1, 3'b000, IMM_I);
    push_fd(); push(4'd7, 1'b1, 7'd0, ALU_SRA); push(4'd8, 1'b1, 7'd0, ALU_ADD);
    set_instr(OP_I, 3'b000, 1'b1, 3'b000, IMM_I);
    push_fd(); push(4'd7, 1'b1, 7'd0, ALU_ADD); push(4'd8, 1'b1, 7'd0, ALU_ADD);
    exp_instret += 5;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op; funct3 = it.f3; funct7_5 = it.f7; {zero, lt, ltu} = it.flg;
      #4;
      total++;
      if (obs() !== it.v) begin bad++; $display("FAIL alu_ops: got %h want %h", obs(), it.v); end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== exp_instret) begin
      bad++; $display("FAIL alu_ops_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_branch();
    item_t it;
    set_instr(OP_BRANCH, 3'b001, 1'b0, 3'b000, IMM_B); push_fd(); push(4'd9, 1'b1, D_PC, ALU_SUB);
    set_instr(OP_BRANCH, 3'b001, 1'b0, 3'b100, IMM_B); push_fd(); push(4'd9, 1'b1, 7'd0, ALU_SUB);
    set_instr(OP_BRANCH, 3'b110, 1'b0, 3'b001, IMM_B); push_fd(); push(4'd9, 1'b1, D_PC, ALU_SUB);
    set_instr(OP_BRANCH, 3'b100, 1'b0, 3'b010, IMM_B); push_fd(); push(4'd9, 1'b1, D_PC, ALU_SUB);
    set_instr(OP_BRANCH, 3'b101, 1'b0, 3'b010, IMM_B); push_fd(); push(4'd9, 1'b1, 7'd0, ALU_SUB);
    exp_instret += 5;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op; funct3 = it.f3; funct7_5 = it.f7; {zero, lt, ltu} = it.flg;
      #4;
      total++;
      if (obs() !== it.v) begin bad++; $display("FAIL branch: got %h want %h", obs(), it.v); end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== exp_instret) begin
      bad++; $display("FAIL branch_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_mem();
    item_t it;
    set_instr(OP_LOAD, 3'b010, 1'b0, 3'b000, IMM_I);
    push(4'd0, 1'b0, 7'd0, ALU_ADD);
    push_fd(); push(4'd2, 1'b1, 7'd0, ALU_ADD);
    repeat (3) push(4'd3, 1'b0, 7'd0, ALU_ADD);
    push(4'd3, 1'b1, 7'd0, ALU_ADD); push(4'd4, 1'b1, 7'd0, ALU_ADD);
    set_instr(OP_STORE, 3'b010, 1'b0, 3'b000, IMM_S);
    push_fd(); push(4'd2, 1'b1, 7'd0, ALU_ADD);
    push(4'd5, 1'b0, 7'd0, ALU_ADD); push(4'd5, 1'b1, 7'd0, ALU_ADD);
    exp_instret += 2;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op; funct3 = it.f3; funct7_5 = it.f7; {zero, lt, ltu} = it.flg;
      #4;
      total++;
      if (obs() !== it.v) begin bad++; $display("FAIL mem: got %h want %h", obs(), it.v); end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== exp_instret) begin
      bad++; $display("FAIL mem_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_illegal_and_jumps();
    item_t it;
    set_instr(7'b0000000, 3'b000, 1'b0, 3'b000, IMM_I);
    push(4'd0, 1'b1, D_IR | D_PC, ALU_ADD); push(4'd1, 1'b1, D_ILL, ALU_ADD);
    set_instr(OP_JALR, 3'b000, 1'b0, 3'b000, IMM_I);
    push_fd(); push(4'd11, 1'b1, 7'd0, ALU_ADD); push(4'd12, 1'b1, 7'd0, ALU_ADD);
    push(4'd8, 1'b1, 7'd0, ALU_ADD);
    set_instr(OP_JAL, 3'b000, 1'b0, 3'b000, IMM_J);
    push_fd(); push(4'd10, 1'b1, 7'd0, ALU_ADD); push(4'd8, 1'b1, 7'd0, ALU_ADD);
    set_instr(OP_LUI, 3'b000, 1'b0, 3'b000, IMM_U);
    push_fd(); push(4'd14, 1'b1, 7'd0, ALU_ADD); push(4'd8, 1'b1, 7'd0, ALU_ADD);
    set_instr(OP_AUIPC, 3'b000, 1'b0, 3'b000, IMM_U);
    push_fd(); push(4'd13, 1'b1, 7'd0, ALU_ADD); push(4'd8, 1'b1, 7'd0, ALU_ADD);
    exp_instret += 4;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op; funct3 = it.f3; funct7_5 = it.f7; {zero, lt, ltu} = it.flg;
      #4;
      total++;
      if (obs() !== it.v) begin bad++; $display("FAIL jumps: got %h want %h", obs(), it.v); end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== exp_instret) begin
      bad++; $display("FAIL jumps_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_reset_mid_write();
    item_t it;
    set_instr(OP_STORE, 3'b010, 1'b0, 3'b000, IMM_S);
    push_fd(); push(4'd2, 1'b1, 7'd0, ALU_ADD);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op; funct3 = it.f3; funct7_5 = it.f7; {zero, lt, ltu} = it.flg;
      #4;
      total++;
      if (obs() !== it.v) begin bad++; $display("FAIL reset_mid seq: got %h want %h", obs(), it.v); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #2;
    total++;
    if (mem_write !== 1'b1 || state_o !== 4'd5) begin
      bad++; $display("FAIL reset_mid pre: mem_write=%b state=%0d want 1/5", mem_write, state_o);
    end
    reset = 1'b0;
    #1;
    total++;
    if (mem_write !== 1'b0 || state_o !== 4'd0 || instret !== 32'd0) begin
      bad++; $display("FAIL reset_mid post: mem_write=%b state=%0d instret=%0d want 0/0/0",
                      mem_write, state_o, instret);
    end
    exp_instret = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    total++;
    if (state_o !== 4'd0 || ir_write !== 1'b1) begin
      bad++; $display("FAIL restart_fetch: state=%0d ir_write=%b want 0/1", state_o, ir_write);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branch();
    test_mem();
    test_illegal_and_jumps();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
